// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. A two-flop synchroniser feeds an FSM that
// validates the start bit at mid-bit, samples eight data bits LSB-first at
// bit centres, checks the stop bit, and pulses rx_done or frame_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic             sync1_r;
  logic             rx_s_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic [7:0]       data_nxt_s;
  logic             done_nxt_s;
  logic             ferr_nxt_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rx_s_r  <= 1'b1;
    end else begin
      sync1_r <= rx_serial;
      rx_s_r  <= sync1_r;
    end
  end

  // Next-state, counter, shift register and output-strobe decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    data_nxt_s    = data_out;
    done_nxt_s    = 1'b0;
    ferr_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (!rx_s_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF_END) begin
          cnt_nxt_s = CNT_ZERO;
          if (!rx_s_r) begin
            state_nxt_s   = ST_DATA;
            bit_idx_nxt_s = 3'd0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_BIT_END) begin
          cnt_nxt_s              = CNT_ZERO;
          shift_nxt_s[bit_idx_r] = rx_s_r;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s   = ST_STOP;
            bit_idx_nxt_s = 3'd0;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_BIT_END) begin
          cnt_nxt_s = CNT_ZERO;
          if (rx_s_r) begin
            data_nxt_s  = shift_r;
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            // Bad stop bit: keep the old byte and wait out the low line.
            ferr_nxt_s  = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_BREAK: begin
        cnt_nxt_s = CNT_ZERO;
        if (rx_s_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = CNT_ZERO;
        bit_idx_nxt_s = 3'd0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_out  <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      data_out  <= data_nxt_s;
      rx_done   <= done_nxt_s;
      frame_err <= ferr_nxt_s;
      rx_busy   <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule
